framebuffer_writer: RTL and testbench
=====================================

// Module: framebuffer_writer
// PURPOSE
//  Sink for (x, y, R, G, B) pixel streams such as the screen-refresh sweep and sprite drawers.
//  Accepts pixels over a valid/ready handshake, range-checks them, and linearises (x,y) to a
//  framebuffer address. It buffers pixels in a small FIFO and drives write cycles to the
//  framebuffer RAM port under that port's ready.
//  It sits between the pixel generators and the VGA framebuffer memory.
// PARAMETERS
//  H_RES    160  horizontal resolution; legal x = 0..H_RES-1
//  V_RES    120  vertical resolution; legal y = 0..V_RES-1
//  ADDR_W   15   framebuffer address width; must hold H_RES*V_RES-1
//  DEPTH    4    FIFO entries (power of two, >=2)
// PORTS
//  clk         in   1       system clock, all logic on posedge
//  reset       in   1       asynchronous, active-high reset
//  in_valid    in   1       pixel request present
//  in_ready    out  1       block can accept a pixel this cycle
//  in_x        in   8       pixel column
//  in_y        in   8       pixel row
//  in_r        in   8       red component
//  in_g        in   8       green component
//  in_b        in   8       blue component
//  mem_we      out  1       write request to framebuffer (valid)
//  mem_ready   in   1       framebuffer accepts write this cycle
//  mem_addr    out  ADDR_W  linear address y*H_RES + x
//  mem_wdata   out  24      packed colour {R,G,B}
//  fill_level  out  $clog2(DEPTH)+1  current FIFO occupancy
//  drop_count  out  16      count of out-of-range pixels, saturating
//  frame_done  out  1       one-cycle pulse after the last pixel address is written
// BEHAVIOUR
//  Reset, asynchronous:
//   - FIFO empty, fill_level=0, mem_we=0, in_ready=1.
//   - drop_count=0, frame_done=0.
//   - mem_addr and mem_wdata are don't-care while mem_we=0.
//   - Reset mid-transfer discards all buffered pixels; no write completes after reset rises.
//  Input handshake:
//   - in_ready = (fill_level != DEPTH), taken from registered state only.
//   - in_ready is not combinationally dependent on in_valid or mem_ready.
//   - A transfer occurs on a posedge with in_valid && in_ready.
//   - A full FIFO holds in_ready=0 even if a pop occurs in the same cycle.
//  Range check at acceptance:
//   - If in_x >= H_RES or in_y >= V_RES, the pixel is consumed but not enqueued.
//   - In that case drop_count increments, saturating at 16'hFFFF.
//  Linearisation:
//   - Compute addr = in_y*H_RES + in_x at full width, then truncate to ADDR_W.
//   - Store addr with {in_r,in_g,in_b} in the FIFO entry.
//  Output:
//   - First-word-fall-through. mem_we = (fill_level != 0).
//   - mem_addr/mem_wdata show the head entry and stay stable while mem_we && !mem_ready.
//   - Pop on a posedge with mem_we && mem_ready.
//  Latency and throughput:
//   - A pixel accepted at edge N into an empty FIFO shows mem_we=1 after edge N.
//   - It can retire at edge N+1.
//   - Sustained rate is 1 pixel/cycle when mem_ready is held at 1.
//  FIFO occupancy:
//   - A push and a pop on the same edge leave fill_level unchanged and preserve ordering.
//   - Pointers wrap modulo DEPTH.
//  frame_done:
//   - Registered. Goes high for exactly one cycle after the edge that pops an entry
//     with addr == H_RES*V_RES-1.
//  Order: pixels are written strictly in acceptance order; none duplicated, none lost.
// TESTING
//  1 Reset, then push (x=0,y=0,RGB=FF,00,00) with mem_ready=1.
//    -> next cycle mem_we=1, mem_addr=0, mem_wdata=24'hFF0000; retired the cycle after.
//  2 Push (x=159,y=119) with mem_ready=1.
//    -> mem_addr=19199; frame_done pulses for 1 cycle after the pop.
//  3 Hold mem_ready=0 and present 5 valid pixels.
//    -> 4 accepted, fill_level=4, in_ready=0, 5th stalls.
//    -> Raise mem_ready: drains in order, 5th accepted once fill_level<4.
//  4 Push x=160,y=0 and x=0,y=200.
//    -> both consumed (in_ready=1), drop_count=2, mem_we stays 0.
//  5 Stream full 160x120 sweep, mem_ready toggling 1/0 every cycle.
//    -> 19200 writes, addresses 0..19199 in order, exactly one frame_done.
//  6 Fill 3 entries, assert reset mid-drain.
//    -> mem_we=0 and fill_level=0 immediately; no further writes before the next input.

Source files
------------

// File: rtl/framebuffer_writer.sv
// framebuffer_writer: accepts (x,y,RGB) pixels, drops off-screen ones,
// linearises (x,y) and buffers writes in a small FWFT FIFO for the RAM port.
module framebuffer_writer #(
    parameter int H_RES  = 160,
    parameter int V_RES  = 120,
    parameter int ADDR_W = 15,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_x,
    input  logic [7:0]              in_y,
    input  logic [7:0]              in_r,
    input  logic [7:0]              in_g,
    input  logic [7:0]              in_b,
    output logic                    mem_we,
    input  logic                    mem_ready,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [23:0]             mem_wdata,
    output logic [$clog2(DEPTH):0]  fill_level,
    output logic [15:0]             drop_count,
    output logic                    frame_done
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [23:0]       data_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              accept;
    logic              in_range;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] push_addr;

    // Handshake flags, range check and address linearisation
    always_comb begin
        in_ready   = (count != CNT_W'(DEPTH));
        mem_we     = (count != '0);
        accept     = in_valid && in_ready;
        in_range   = (32'(in_x) < 32'(H_RES)) && (32'(in_y) < 32'(V_RES));
        push       = accept && in_range;
        pop        = mem_we && mem_ready;
        push_addr  = ADDR_W'(32'(in_y) * 32'(H_RES) + 32'(in_x));
        mem_addr   = addr_mem[rd_ptr];
        mem_wdata  = data_mem[rd_ptr];
        fill_level = count;
    end

    // FIFO storage; contents are don't-care until the count covers them
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= {in_r, in_g, in_b};
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

    // Saturating counter of off-screen pixels that were consumed
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            drop_count <= '0;
        else if (accept && !in_range && drop_count != 16'hFFFF)
            drop_count <= drop_count + 16'd1;
    end

    // One-cycle pulse once the last screen address has been written
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            frame_done <= 1'b0;
        else
            frame_done <= pop && (mem_addr == LAST_ADDR);
    end

endmodule

// File: tb/tb_framebuffer_writer.sv
// tb_framebuffer_writer: directed steps with a scoreboard queue of expected
// framebuffer writes, compared whenever the DUT retires a write.
module tb_framebuffer_writer;

    typedef struct {
        logic [14:0] addr;
        logic [23:0] data;
    } exp_t;

    localparam int LAST = 160 * 120 - 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_x = '0;
    logic [7:0]  in_y = '0;
    logic [7:0]  in_r = '0;
    logic [7:0]  in_g = '0;
    logic [7:0]  in_b = '0;
    logic        mem_we;
    logic        mem_ready = 1'b0;
    logic [14:0] mem_addr;
    logic [23:0] mem_wdata;
    logic [2:0]  fill_level;
    logic [15:0] drop_count;
    logic        frame_done;

    int   checks = 0;
    int   errors = 0;
    int   writes = 0;
    int   fd_count = 0;
    bit   toggle = 0;
    bit   exp_fd = 0;
    exp_t sb[$];

    framebuffer_writer dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_r       (in_r),
        .in_g       (in_g),
        .in_b       (in_b),
        .mem_we     (mem_we),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .fill_level (fill_level),
        .drop_count (drop_count),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mem_ready toggles every cycle while toggle mode is on
    initial forever begin
        @(posedge clk);
        #1;
        if (toggle)
            mem_ready = !mem_ready;
    end

    // Monitor at negedge: inputs are stable until the next posedge
    always @(negedge clk) begin
        exp_t e;
        int   a;
        if (reset) begin
            sb.delete();
            exp_fd = 0;
        end else begin
            chk("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
            exp_fd = 0;
            if (mem_we && mem_ready) begin
                writes++;
                if (sb.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("wr_addr", {17'd0, mem_addr}, {17'd0, e.addr});
                    chk("wr_data", {8'd0, mem_wdata}, {8'd0, e.data});
                    if (e.addr == 15'(LAST))
                        exp_fd = 1;
                end
            end
            if (in_valid && in_ready && in_x < 8'd160 && in_y < 8'd120) begin
                a = int'(in_y) * 160 + int'(in_x);
                e.addr = 15'(a);
                e.data = {in_r, in_g, in_b};
                sb.push_back(e);
            end
        end
        if (frame_done)
            fd_count++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_x = x;
        in_y = y;
        in_r = r;
        in_g = g;
        in_b = b;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready)
            chk("send_timeout", 32'd1, 32'd0);
        step(1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((fill_level != 0 || sb.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_fill", {29'd0, fill_level}, 32'd0);
        chk("drain_sb", sb.size(), 32'd0);
        step(1);
    endtask

    initial begin
        int w0;
        int f0;
        // Reset state
        step(3);
        reset = 1'b0;
        chk("rst_fill", {29'd0, fill_level}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_drop", {16'd0, drop_count}, 32'd0);
        chk("rst_fd", {31'd0, frame_done}, 32'd0);

        // 1: single pixel, one-cycle latency, retires next edge
        mem_ready = 1'b1;
        send(8'd0, 8'd0, 8'hFF, 8'h00, 8'h00);
        chk("t1_we", {31'd0, mem_we}, 32'd1);
        chk("t1_addr", {17'd0, mem_addr}, 32'd0);
        chk("t1_data", {8'd0, mem_wdata}, 32'hFF0000);
        step(1);
        chk("t1_retired", {31'd0, mem_we}, 32'd0);

        // 2: last screen address and frame_done pulse
        send(8'd159, 8'd119, 8'd1, 8'd2, 8'd3);
        chk("t2_addr", {17'd0, mem_addr}, 32'd19199);
        f0 = fd_count;
        step(1);
        chk("t2_fd_hi", {31'd0, frame_done}, 32'd1);
        step(1);
        chk("t2_fd_lo", {31'd0, frame_done}, 32'd0);
        chk("t2_fd_cnt", fd_count - f0, 32'd1);

        // 3: stall with full FIFO, 5th pixel waits
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(8'(10 + i), 8'd5, 8'(i), 8'h55, 8'hAA);
        chk("t3_fill", {29'd0, fill_level}, 32'd4);
        chk("t3_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1;
        in_x = 8'd14;
        in_y = 8'd5;
        in_r = 8'd4;
        in_g = 8'h55;
        in_b = 8'hAA;
        step(3);
        chk("t3_stall_ready", {31'd0, in_ready}, 32'd0);
        chk("t3_stall_addr", {17'd0, mem_addr}, 32'd810);
        chk("t3_stall_fill", {29'd0, fill_level}, 32'd4);
        mem_ready = 1'b1;
        send(8'd14, 8'd5, 8'd4, 8'h55, 8'hAA);
        drain();

        // 4: off-screen pixels are consumed and counted
        send(8'd160, 8'd0, 8'd9, 8'd9, 8'd9);
        chk("t4_we_a", {31'd0, mem_we}, 32'd0);
        send(8'd0, 8'd200, 8'd9, 8'd9, 8'd9);
        chk("t4_we_b", {31'd0, mem_we}, 32'd0);
        chk("t4_ready", {31'd0, in_ready}, 32'd1);
        chk("t4_drop", {16'd0, drop_count}, 32'd2);

        // 5: full sweep with mem_ready toggling
        w0 = writes;
        f0 = fd_count;
        toggle = 1;
        for (int y = 0; y < 120; y++)
            for (int x = 0; x < 160; x++)
                send(8'(x), 8'(y), 8'(x), 8'(y), 8'(x ^ y));
        drain();
        toggle = 0;
        step(2);
        chk("t5_writes", writes - w0, 32'd19200);
        chk("t5_fd_cnt", fd_count - f0, 32'd1);

        // 6: reset mid-drain discards buffered pixels
        mem_ready = 1'b0;
        step(1);
        send(8'd1, 8'd1, 8'd1, 8'd1, 8'd1);
        send(8'd2, 8'd1, 8'd2, 8'd2, 8'd2);
        send(8'd3, 8'd1, 8'd3, 8'd3, 8'd3);
        chk("t6_fill", {29'd0, fill_level}, 32'd3);
        mem_ready = 1'b1;
        step(1);
        reset = 1'b1;
        #1;
        chk("t6_rst_we", {31'd0, mem_we}, 32'd0);
        chk("t6_rst_fill", {29'd0, fill_level}, 32'd0);
        chk("t6_rst_ready", {31'd0, in_ready}, 32'd1);
        step(2);
        reset = 1'b0;
        w0 = writes;
        step(5);
        chk("t6_no_write", writes - w0, 32'd0);
        chk("t6_we_idle", {31'd0, mem_we}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
